cache_refill_ctrl: RTL and testbench
====================================

// Module: cache_refill_ctrl
// PURPOSE
//  Miss-handling stage directly downstream of the direct-mapped block cache.
//  - On a read miss, fetches the whole line from main memory one word at a time.
//  - Assembles the 128-bit block and issues a one-cycle cache write with the line address.
//  - Stalls the core (busy) until the line is written.
// PARAMETERS
//  ADDR_W   32  byte-address width
//  WORD_W   32  memory word width
//  WORDS    4   words per line (power of 2, >=2); line = WORDS*WORD_W bits
// PORTS
//  clk         in   1              rising-edge clock
//  rst_n       in   1              asynchronous active-low reset
//  miss_req    in   1              cache read miss; level, held by upstream until done
//  miss_addr   in   ADDR_W         byte address of the missing read
//  busy        out  1              refill in progress; core must stall
//  mem_req     out  1              word read request to main memory
//  mem_addr    out  ADDR_W         word-aligned request address
//  mem_gnt     in   1              memory accepts request (req&gnt = handshake)
//  mem_rvalid  in   1              read data valid
//  mem_rdata   in   WORD_W         read data
//  fill_we     out  1              one-cycle cache write strobe (drives cache read=0)
//  fill_addr   out  ADDR_W         line address, offset bits zero
//  fill_block  out  WORDS*WORD_W   assembled line, word i at bits [i*WORD_W +: WORD_W]
//  fill_word   out  WORD_W         word originally requested, valid with fill_we
//  done        out  1              one-cycle pulse, same cycle as fill_we
//  fwd_valid   out  1              early-forward strobe (see CONFIGURATION)
//  fwd_data    out  WORD_W         early-forward data
// BEHAVIOUR
//  - Reset: all outputs 0, line buffer 0, beat counter 0, state IDLE.
//  - States: IDLE, REQ, WAIT, FILL.
//  - IDLE: miss_req=1 -> latch miss_addr; busy=1 next cycle; cnt=start offset; go to REQ.
//  - REQ: mem_req=1, mem_addr={line_base, cnt, 2'b00}; both held stable until mem_gnt.
//    On mem_gnt -> WAIT, mem_req=0.
//  - WAIT: on mem_rvalid, store mem_rdata in slot cnt.
//    After the last of WORDS beats -> FILL; otherwise cnt+1 (mod WORDS) -> REQ.
//  - FILL: fill_we=1 and done=1 for exactly one cycle.
//    fill_addr and fill_block valid; busy drops the next cycle; -> IDLE.
//  - At most one outstanding memory request; mem_rvalid outside WAIT is ignored.
//  - Counter wraps within the line only; mem_addr never leaves line_base.
//  - Latency, zero-wait memory (gnt in REQ cycle, rvalid next cycle): fill_we 2*WORDS+1
//    cycles after the miss_req acceptance edge.
//  - miss_req while busy is ignored (no queueing).
//  - miss_req still high in the cycle after done starts a new refill; upstream drops it on done.
//  - fill_block holds its value in IDLE until the next refill overwrites it.
//  - Reset mid-refill: aborts immediately; no fill_we; memory response after reset ignored.
// CONFIGURATION
//  - CRITICAL_WORD_FIRST_EN defined:
//    - start offset = miss_addr word offset; order e.g. 2,3,0,1 for offset 2.
//    - On the first returned beat: fwd_valid=1 for one cycle, fwd_data = that word.
//  - Not defined:
//    - start offset = 0; order 0..WORDS-1.
//    - fwd_valid and fwd_data tied to 0.
//  - fill_block layout and fill timing are identical in both builds.
// TESTING
//  1. Reset: assert rst_n=0 mid-REQ -> mem_req, busy, fill_we, done all 0 async; no later fill.
//  2. Basic refill: miss_addr=0x0000_1234, zero-wait memory returning 0xA0..0xA3.
//     -> mem_addr 0x1230,0x1234,0x1238,0x123C.
//     -> fill_addr=0x1230; fill_block={A3,A2,A1,A0}; fill_word=A1; fill_we at cycle 9.
//  3. Stalled grant: hold mem_gnt=0 for 5 cycles on beat 2.
//     -> mem_req and mem_addr stable throughout; fill_we 5 cycles later; same block.
//  4. Spurious rvalid pulse in IDLE/REQ, and miss_req toggled while busy
//     -> no extra beats stored; single fill_we.
//  5. Back-to-back misses 0x40 then 0x80 -> two fills, fill_addr 0x40 then 0x80.
//     busy low exactly one cycle between the two refills.
//  6. CRITICAL_WORD_FIRST_EN, miss_addr=0x38:
//     -> mem_addr order 0x38,0x3C,0x30,0x34.
//     -> fwd_valid on first beat with fwd_data=word2.
//     -> fill_block slots match the no-macro build.

Source files
------------

// File: rtl/cache_refill_ctrl_if.sv
// cache_refill_ctrl_if: miss request, memory read port and cache fill bundle.
// master = refill controller side, slave = cache/memory environment side.
interface cache_refill_ctrl_if #(
   parameter int ADDR_W = 32,
   parameter int WORD_W = 32,
   parameter int WORDS  = 4
);
   logic                      miss_req;
   logic [ADDR_W-1:0]         miss_addr;
   logic                      busy;
   logic                      mem_req;
   logic [ADDR_W-1:0]         mem_addr;
   logic                      mem_gnt;
   logic                      mem_rvalid;
   logic [WORD_W-1:0]         mem_rdata;
   logic                      fill_we;
   logic [ADDR_W-1:0]         fill_addr;
   logic [WORDS*WORD_W-1:0]   fill_block;
   logic [WORD_W-1:0]         fill_word;
   logic                      done;
   logic                      fwd_valid;
   logic [WORD_W-1:0]         fwd_data;

   modport master (
      input  miss_req, miss_addr,
      input  mem_gnt, mem_rvalid, mem_rdata,
      output busy, mem_req, mem_addr,
      output fill_we, fill_addr, fill_block, fill_word,
      output done, fwd_valid, fwd_data
   );

   modport slave (
      output miss_req, miss_addr,
      output mem_gnt, mem_rvalid, mem_rdata,
      input  busy, mem_req, mem_addr,
      input  fill_we, fill_addr, fill_block, fill_word,
      input  done, fwd_valid, fwd_data
   );
endinterface

// File: rtl/cache_refill_ctrl.sv
// cache_refill_ctrl: fetches a missing line word by word and writes it to the cache.
// Build macro CRITICAL_WORD_FIRST_EN: fetch the requested word first and forward it early.
module cache_refill_ctrl #(
   parameter int ADDR_W = 32,
   parameter int WORD_W = 32,
   parameter int WORDS  = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   cache_refill_ctrl_if.master rf_io
);
   localparam int OFF_W  = $clog2(WORD_W / 8);
   localparam int CW     = $clog2(WORDS);
   localparam int BASE_W = ADDR_W - CW - OFF_W;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT,
      FILL
   } state_e;

   state_e                         state_q;
   logic [BASE_W-1:0]              base_q;
   logic [CW-1:0]                  cnt_q;
   logic [CW-1:0]                  beats_q;
   logic [CW-1:0]                  crit_q;
   logic                           busy_q;
   logic                           mem_req_q;
   logic [ADDR_W-1:0]              mem_addr_q;
   logic                           fill_we_q;
   logic                           done_q;
   logic [ADDR_W-1:0]              fill_addr_q;
   logic [WORDS-1:0][WORD_W-1:0]   line_q;
   logic [WORD_W-1:0]              fill_word_q;

   logic [WORDS-1:0][WORD_W-1:0]   line_d;
   logic [CW-1:0]                  start_d;
   logic [CW-1:0]                  cnt_inc;
   logic                           last_beat;

`ifdef CRITICAL_WORD_FIRST_EN
   logic                           fwd_valid_q;
   logic [WORD_W-1:0]              fwd_data_q;
`endif

   always_comb begin
      line_d = line_q;
      line_d[cnt_q] = rf_io.mem_rdata;
   end

`ifdef CRITICAL_WORD_FIRST_EN
   assign start_d = rf_io.miss_addr[OFF_W +: CW];
`else
   assign start_d = '0;
`endif

   assign cnt_inc   = cnt_q + CW'(1);
   assign last_beat = (beats_q == CW'(WORDS - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         base_q      <= '0;
         cnt_q       <= '0;
         beats_q     <= '0;
         crit_q      <= '0;
         busy_q      <= 1'b0;
         mem_req_q   <= 1'b0;
         mem_addr_q  <= '0;
         fill_we_q   <= 1'b0;
         done_q      <= 1'b0;
         fill_addr_q <= '0;
         line_q      <= '0;
         fill_word_q <= '0;
`ifdef CRITICAL_WORD_FIRST_EN
         fwd_valid_q <= 1'b0;
         fwd_data_q  <= '0;
`endif
      end else begin
         fill_we_q <= 1'b0;
         done_q    <= 1'b0;
`ifdef CRITICAL_WORD_FIRST_EN
         fwd_valid_q <= 1'b0;
`endif
         unique case (state_q)
            IDLE: begin
               if (rf_io.miss_req) begin
                  base_q     <= rf_io.miss_addr[ADDR_W-1 -: BASE_W];
                  crit_q     <= rf_io.miss_addr[OFF_W +: CW];
                  cnt_q      <= start_d;
                  beats_q    <= '0;
                  busy_q     <= 1'b1;
                  mem_req_q  <= 1'b1;
                  mem_addr_q <= {rf_io.miss_addr[ADDR_W-1 -: BASE_W],
                                 start_d, {OFF_W{1'b0}}};
                  state_q    <= REQ;
               end
            end
            REQ: begin
               if (rf_io.mem_gnt) begin
                  mem_req_q <= 1'b0;
                  state_q   <= WAIT;
               end
            end
            WAIT: begin
               if (rf_io.mem_rvalid) begin
                  line_q <= line_d;
`ifdef CRITICAL_WORD_FIRST_EN
                  if (beats_q == '0) begin
                     fwd_valid_q <= 1'b1;
                     fwd_data_q  <= rf_io.mem_rdata;
                  end
`endif
                  if (last_beat) begin
                     fill_we_q   <= 1'b1;
                     done_q      <= 1'b1;
                     fill_addr_q <= {base_q, {(CW + OFF_W){1'b0}}};
                     fill_word_q <= line_d[crit_q];
                     state_q     <= FILL;
                  end else begin
                     cnt_q      <= cnt_inc;
                     beats_q    <= beats_q + CW'(1);
                     mem_req_q  <= 1'b1;
                     mem_addr_q <= {base_q, cnt_inc, {OFF_W{1'b0}}};
                     state_q    <= REQ;
                  end
               end
            end
            FILL: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign rf_io.busy       = busy_q;
   assign rf_io.mem_req    = mem_req_q;
   assign rf_io.mem_addr   = mem_addr_q;
   assign rf_io.fill_we    = fill_we_q;
   assign rf_io.done       = done_q;
   assign rf_io.fill_addr  = fill_addr_q;
   assign rf_io.fill_block = line_q;
   assign rf_io.fill_word  = fill_word_q;

`ifdef CRITICAL_WORD_FIRST_EN
   assign rf_io.fwd_valid = fwd_valid_q;
   assign rf_io.fwd_data  = fwd_data_q;
`else
   assign rf_io.fwd_valid = 1'b0;
   assign rf_io.fwd_data  = '0;
`endif
endmodule

// File: tb/tb_cache_refill_ctrl.sv
// tb_cache_refill_ctrl: directed bench for the line refill controller.
// Memory responder grants in the request cycle and returns data one cycle later.
module tb_cache_refill_ctrl;
   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   acc = 0;
   int   fill_cnt = 0;
   int   fwd_cnt = 0;
   logic [31:0] fwd_last = '0;

   int          granted = 0;
   int          stall_beat = 0;
   int          stall_len = 0;
   int          stall_left = 0;
   logic        issue = 1'b0;
   logic        spur = 1'b0;
   logic [31:0] iss_addr = '0;
   logic [31:0] stall_addr = '0;
   logic [31:0] dbase = '0;
   logic [31:0] addr_q[$];

   cache_refill_ctrl_if #(.ADDR_W(32), .WORD_W(32), .WORDS(4)) bus ();

   cache_refill_ctrl #(.ADDR_W(32), .WORD_W(32), .WORDS(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .rf_io (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [127:0] obs,
                        input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Memory model: word data = dbase + slot index of the requested address.
   always @(negedge clk) begin
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = '0;
      if (issue) begin
         bus.mem_rvalid = 1'b1;
         bus.mem_rdata  = dbase + 32'(iss_addr[3:2]);
         issue = 1'b0;
      end else if (spur) begin
         bus.mem_rvalid = 1'b1;
         bus.mem_rdata  = 32'hDEAD_BEEF;
      end
      if (stall_left > 0 && stall_left < stall_len && granted == stall_beat) begin
         check("stall req held", 128'(bus.mem_req), 128'd1);
         check("stall addr held", 128'(bus.mem_addr), 128'(stall_addr));
      end
      bus.mem_gnt = 1'b0;
      if (bus.mem_req === 1'b1) begin
         if (granted == stall_beat && stall_left > 0) begin
            if (stall_left == stall_len) stall_addr = bus.mem_addr;
            stall_left--;
         end else begin
            bus.mem_gnt = 1'b1;
            issue = 1'b1;
            iss_addr = bus.mem_addr;
            addr_q.push_back(bus.mem_addr);
            granted++;
         end
      end
   end

   always @(negedge clk) begin
      if (bus.fill_we === 1'b1) fill_cnt++;
      if (bus.fwd_valid === 1'b1) begin
         fwd_cnt++;
         fwd_last = bus.fwd_data;
      end
   end

   task automatic start_miss(input logic [31:0] a);
      @(negedge clk);
      bus.miss_addr = a;
      bus.miss_req  = 1'b1;
      @(posedge clk);
      #1;
      acc = cyc;
   endtask

   task automatic wait_done();
      int n = 0;
      while (bus.done !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("done seen", 128'(bus.done), 128'd1);
   endtask

   // Cycle 1 is the first cycle after the acceptance edge.
   task automatic check_fill(input string tag, input logic [31:0] fa,
                             input logic [127:0] blk, input logic [31:0] fw,
                             input int fcyc);
      check({tag, " fill_we"}, 128'(bus.fill_we), 128'd1);
      check({tag, " busy in fill"}, 128'(bus.busy), 128'd1);
      check({tag, " fill_addr"}, 128'(bus.fill_addr), 128'(fa));
      check({tag, " fill_block"}, bus.fill_block, blk);
      check({tag, " fill_word"}, 128'(bus.fill_word), 128'(fw));
      check({tag, " fill cycle"}, 128'(cyc - acc + 1), 128'(fcyc));
   endtask

   task automatic check_addrs(input string tag, input logic [31:0] e0,
                              input logic [31:0] e1, input logic [31:0] e2,
                              input logic [31:0] e3);
      logic [31:0] e[4];
      e = '{e0, e1, e2, e3};
      check({tag, " beats"}, 128'(addr_q.size()), 128'd4);
      for (int i = 0; i < 4; i++)
         check({tag, " mem_addr"}, 128'(addr_q.size() > i ? addr_q[i] : 32'hX),
               128'(e[i]));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int fc0;
      rst_n = 1'b0;
      bus.miss_req  = 1'b0;
      bus.miss_addr = '0;
      repeat (2) @(negedge clk);
      check("rst busy", 128'(bus.busy), 128'd0);
      check("rst mem_req", 128'(bus.mem_req), 128'd0);
      check("rst mem_addr", 128'(bus.mem_addr), 128'd0);
      check("rst fill_we", 128'(bus.fill_we), 128'd0);
      check("rst done", 128'(bus.done), 128'd0);
      check("rst fill_block", bus.fill_block, 128'd0);
      check("rst fwd_valid", 128'(bus.fwd_valid), 128'd0);
      rst_n = 1'b1;

      // Reset while a request waits for grant.
      granted = 0; stall_beat = 0; stall_len = 10; stall_left = 10;
      dbase = 32'hE0;
      start_miss(32'h0000_2000);
      repeat (2) @(negedge clk);
      check("midreq req", 128'(bus.mem_req), 128'd1);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      stall_left = 0;
      #1;
      check("async mem_req", 128'(bus.mem_req), 128'd0);
      check("async busy", 128'(bus.busy), 128'd0);
      check("async fill_we", 128'(bus.fill_we), 128'd0);
      check("async done", 128'(bus.done), 128'd0);
      @(negedge clk);
      bus.miss_req = 1'b0;
      spur = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      #1 spur = 1'b0;
      repeat (20) @(negedge clk);
      #1;
      check("no fill after reset", 128'(fill_cnt), 128'd0);
      check("idle after reset", 128'(bus.busy), 128'd0);

      // Basic zero-wait refill.
      addr_q.delete(); granted = 0; dbase = 32'hA0; fwd_cnt = 0;
      start_miss(32'h0000_1234);
      wait_done();
      check_fill("basic", 32'h1230, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 32'hA1, 9);
      bus.miss_req = 1'b0;
      @(negedge clk);
      check("basic we pulse", 128'(bus.fill_we), 128'd0);
      check("basic done pulse", 128'(bus.done), 128'd0);
      check("basic busy drop", 128'(bus.busy), 128'd0);
      #1;
`ifdef CRITICAL_WORD_FIRST_EN
      check_addrs("basic", 32'h1234, 32'h1238, 32'h123C, 32'h1230);
      check("basic fwd count", 128'(fwd_cnt), 128'd1);
      check("basic fwd data", 128'(fwd_last), 128'hA1);
`else
      check_addrs("basic", 32'h1230, 32'h1234, 32'h1238, 32'h123C);
      check("basic fwd count", 128'(fwd_cnt), 128'd0);
`endif

      // Grant withheld five cycles on the third beat.
      addr_q.delete(); granted = 0;
      stall_beat = 2; stall_len = 5; stall_left = 5;
      start_miss(32'h0000_1234);
      wait_done();
      check_fill("stall", 32'h1230, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 32'hA1, 14);
      bus.miss_req = 1'b0;
      @(negedge clk);
      #1;
      check("stall beats", 128'(addr_q.size()), 128'd4);

      // Spurious rvalid in IDLE and REQ, miss_req toggled while busy.
      addr_q.delete(); granted = 0; stall_left = 0; fc0 = fill_cnt;
      @(negedge clk);
      #1 spur = 1'b1;
      @(negedge clk);
      #1 spur = 1'b0;
      start_miss(32'h0000_1234);
      spur = 1'b1;
      @(negedge clk);
      #1 spur = 1'b0;
      repeat (2) @(negedge clk);
      bus.miss_req = 1'b0;
      @(negedge clk);
      bus.miss_req  = 1'b1;
      bus.miss_addr = 32'h0000_9990;
      @(negedge clk);
      bus.miss_req = 1'b0;
      wait_done();
      check_fill("spur", 32'h1230, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 32'hA1, 9);
      repeat (12) @(negedge clk);
      #1;
      check("spur single fill", 128'(fill_cnt - fc0), 128'd1);
      check("spur beats", 128'(addr_q.size()), 128'd4);
      check("spur idle", 128'(bus.busy), 128'd0);

      // Back-to-back misses.
      addr_q.delete(); granted = 0; dbase = 32'hB0;
      start_miss(32'h0000_0040);
      wait_done();
      check_fill("b2b first", 32'h40, {32'hB3, 32'hB2, 32'hB1, 32'hB0}, 32'hB0, 9);
      bus.miss_addr = 32'h0000_0080;
      @(negedge clk);
      check("b2b gap busy low", 128'(bus.busy), 128'd0);
      @(posedge clk);
      #1;
      acc = cyc;
      @(negedge clk);
      check("b2b busy again", 128'(bus.busy), 128'd1);
      wait_done();
      check_fill("b2b second", 32'h80, {32'hB3, 32'hB2, 32'hB1, 32'hB0}, 32'hB0, 9);
      bus.miss_req = 1'b0;
      @(negedge clk);
      #1;
      check("b2b beats", 128'(addr_q.size()), 128'd8);

      // Miss on word 2 of line 0x30.
      addr_q.delete(); granted = 0; dbase = 32'hC0; fwd_cnt = 0;
      start_miss(32'h0000_0038);
      wait_done();
      check_fill("cwf", 32'h30, {32'hC3, 32'hC2, 32'hC1, 32'hC0}, 32'hC2, 9);
      bus.miss_req = 1'b0;
      @(negedge clk);
      #1;
`ifdef CRITICAL_WORD_FIRST_EN
      check_addrs("cwf", 32'h38, 32'h3C, 32'h30, 32'h34);
      check("cwf fwd count", 128'(fwd_cnt), 128'd1);
      check("cwf fwd data", 128'(fwd_last), 128'hC2);
`else
      check_addrs("cwf", 32'h30, 32'h34, 32'h38, 32'h3C);
      check("cwf fwd count", 128'(fwd_cnt), 128'd0);
      check("cwf fwd data", 128'(bus.fwd_data), 128'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
